store_execution: RTL

STORE_EXECUTION -- requirements
Module: store_execution

---
 rtl/store_execution.sv | 137 +++++++++++++
 1 files changed

// File: rtl/store_execution.sv
// Streams a vector buffer out to byte-wide DRAM: fetches one tile at a time,
// then writes its elements at ascending addresses under a valid/ready handshake.
module store_execution #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [4:0]                                 opcode,
  input  logic [4:0]                                 src_buffer_id,
  input  logic [9:0]                                 length,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  output logic                                       done,
  output logic                                       vec_read_enable,
  output logic [4:0]                                 vec_read_buffer_id,
  output logic [9:0]                                 vec_read_tile_idx,
  input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] vec_read_tile,
  input  logic                                       vec_read_valid,
  output logic                                       mem_we,
  output logic [ADDR_WIDTH-1:0]                      mem_addr,
  output logic [DATA_WIDTH-1:0]                      mem_wdata,
  input  logic                                       mem_ready,
  output logic [2:0]                                 dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_TILE  = 3'd1,
    S_WAIT_TILE = 3'd2,
    S_WRITE     = 3'd3,
    S_COMPLETE  = 3'd4
  } state_e;

  localparam logic [4:0] OP_STORE_V = 5'h03;
  localparam int EIDX_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

  state_e                              state_q, state_d;
  logic [4:0]                          buf_q, buf_d;
  logic [9:0]                          len_q, len_d;
  logic [ADDR_WIDTH-1:0]               base_q, base_d;
  logic [9:0]                          cnt_q, cnt_d;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_q, tile_d;

  logic [10:0]       cnt_inc;
  logic [EIDX_W-1:0] elem_idx;
  logic              tile_end;

  // Handshake: a write transfers at a rising edge where mem_we and mem_ready
  // are both 1; mem_we/mem_addr/mem_wdata hold steady until that edge.
  assign cnt_inc            = {1'b0, cnt_q} + 11'd1;
  assign elem_idx           = EIDX_W'(32'(cnt_q) % TILE_ELEMS);
  assign tile_end           = (32'(cnt_inc) % TILE_ELEMS) == 0;
  assign vec_read_buffer_id = buf_q;
  assign vec_read_tile_idx  = 10'(32'(cnt_q) / TILE_ELEMS);
  assign dbg_state          = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    buf_d           = buf_q;
    len_d           = len_q;
    base_d          = base_q;
    cnt_d           = cnt_q;
    tile_d          = tile_q;
    done            = 1'b0;
    vec_read_enable = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_STORE_V && length != 10'd0) begin
            buf_d   = src_buffer_id;
            len_d   = length;
            base_d  = addr;
            cnt_d   = '0;
            state_d = S_REQ_TILE;
          end else begin
            state_d = S_COMPLETE;
          end
        end
      end
      S_REQ_TILE: begin
        vec_read_enable = 1'b1;
        state_d         = S_WAIT_TILE;
      end
      S_WAIT_TILE: begin
        if (vec_read_valid) begin
          tile_d  = vec_read_tile;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(cnt_q);
        mem_wdata = tile_q[elem_idx];
        if (mem_ready) begin
          cnt_d = cnt_inc[9:0];
          // Finishing the command takes priority over fetching the next tile.
          if (cnt_inc == {1'b0, len_q}) begin
            state_d = S_COMPLETE;
          end else if (tile_end) begin
            state_d = S_REQ_TILE;
          end
        end
      end
      S_COMPLETE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
